// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, FSM encodings and the queue entry type for the
// instruction fetch front end.
//   ADDR    - instruction address width (word addressed)
//   W_INST  - instruction word width
//   S_*     - fetch FSM encodings (2 bits)
package fetch_unit_pkg;

    localparam int unsigned ADDR   = 16;
    localparam int unsigned W_INST = 32;

    localparam logic [1:0] S_IDLE = 2'd0;  // no request outstanding
    localparam logic [1:0] S_WAIT = 2'd1;  // request outstanding, result kept
    localparam logic [1:0] S_DROP = 2'd2;  // request outstanding, result discarded

    // One queued fetch: the word and the address it came from.
    typedef struct packed {
        logic [ADDR-1:0]   pc;
        logic [W_INST-1:0] inst;
    } fq_entry_t;

    // PC arithmetic wraps modulo 2^ADDR.
    function automatic logic [ADDR-1:0] pc_add(input logic [ADDR-1:0] pc,
                                               input logic [ADDR-1:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory port, the decode port and the
// branch redirect input of the fetch unit.
//   master - fetch unit side (drives imem request and the queue head)
//   slave  - environment side (memory, decode and branch unit)
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              imem_req_o;
    logic [ADDR-1:0]   imem_addr_o;
    logic              imem_ack_i;
    logic [W_INST-1:0] imem_data_i;
    logic              inst_valid_o;
    logic [W_INST-1:0] inst_o;
    logic [ADDR-1:0]   inst_pc_o;
    logic              stall_i;
    logic              branch_i;
    logic [ADDR-1:0]   branch_addr_i;

    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  imem_ack_i, imem_data_i, stall_i, branch_i, branch_addr_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output imem_ack_i, imem_data_i, stall_i, branch_i, branch_addr_i
    );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: QDEPTH-entry FIFO of {pc, inst} between fetch and decode.
//   clk, rst    - clock, asynchronous active-high reset
//   push        - write push_data at the tail
//   pop         - drop the head
//   flush       - empty the queue; beats push and pop
//   count       - current occupancy
//   head_valid  - queue not empty
//   head        - oldest entry
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned CNT_W  = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fq_entry_t        push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output fq_entry_t        head
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    fq_entry_t        mem_q [QDEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count_q != '0) && !flush;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push && !flush && ((count_q != CNT_W'(QDEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: it is only visible while head_valid is set.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pipeline front end. Holds the PC, issues one outstanding
// instruction-memory request at a time, buffers returned words in a 2-entry
// queue towards decode and redirects/squashes on taken branches.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - fetch_unit_if.master: imem request/ack/data, decode head and
//              stall, branch redirect
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR-1:0] RESET_PC = '0,
    parameter logic [ADDR-1:0] PC_STEP  = ADDR'(1),
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [1:0]       state_q, state_d;
    logic [ADDR-1:0]  pc_q, pc_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic             req_q, req_d;

    logic             q_push, q_pop, q_valid;
    logic [CNT_W-1:0] q_count;
    fq_entry_t        q_head, q_in;
    logic [OCC_W-1:0] occ_next;
    logic             credit;

    assign q_pop  = q_valid & ~bus.stall_i & ~bus.branch_i;
    assign q_push = (state_q == S_WAIT) & bus.imem_ack_i & ~bus.branch_i;
    assign q_in   = '{pc: addr_q, inst: bus.imem_data_i};

    // Room must remain after this edge's push/pop so the reply always fits.
    assign occ_next = {1'b0, q_count} + OCC_W'(q_push) - OCC_W'(q_pop);
    assign credit   = (occ_next < OCC_W'(QDEPTH)) & ~bus.branch_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.branch_i) begin
                    pc_d = bus.branch_addr_i;
                end else if (credit) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    pc_d    = pc_add(pc_q, PC_STEP);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_ack_i) begin
                    if (bus.branch_i) begin
                        pc_d    = bus.branch_addr_i;
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end else if (credit) begin
                        // Back-to-back issue keeps one word per cycle.
                        addr_d = pc_q;
                        pc_d   = pc_add(pc_q, PC_STEP);
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (bus.branch_i) begin
                    // Request must stay stable until acked; its data is squashed.
                    pc_d    = bus.branch_addr_i;
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.branch_i) pc_d = bus.branch_addr_i;
                if (bus.imem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_data  (q_in),
        .pop        (q_pop),
        .flush      (bus.branch_i),
        .count      (q_count),
        .head_valid (q_valid),
        .head       (q_head)
    );

    assign bus.imem_req_o   = req_q;
    assign bus.imem_addr_o  = addr_q;
    assign bus.inst_valid_o = q_valid;
    assign bus.inst_o       = q_valid ? q_head.inst : '0;
    assign bus.inst_pc_o    = q_valid ? q_head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a memory responder whose
// ack latency is programmable; data word = {16'hA5A5, address}.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (16'h0010),
        .PC_STEP  (16'h0001),
        .QDEPTH   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int ack_delay = 0;
    int wait_cnt  = 0;
    int ack_cnt   = 0;
    int base;

    // Memory model: ack after ack_delay wait cycles of a held request.
    assign bus.imem_ack_i  = bus.imem_req_o && (wait_cnt == ack_delay);
    assign bus.imem_data_i = {16'hA5A5, bus.imem_addr_o};

    always @(posedge clk) begin
        if (!bus.imem_req_o || bus.imem_ack_i) wait_cnt <= 0;
        else                                   wait_cnt <= wait_cnt + 1;
        if (bus.imem_ack_i) ack_cnt <= ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc, input string tag);
        int n = 0;
        while (!bus.inst_valid_o && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.inst_valid_o), 32'd1);
    endtask

    task automatic wait_new_req(input logic [ADDR-1:0] old, input int max_cyc,
                                input string tag);
        int n = 0;
        while (!(bus.imem_req_o && bus.imem_addr_o != old) && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.imem_req_o), 32'd1);
    endtask

    initial begin
        rst               = 1'b1;
        bus.stall_i       = 1'b0;
        bus.branch_i      = 1'b0;
        bus.branch_addr_i = '0;
        #2;
        check("rst_req",   32'(bus.imem_req_o),   32'd0);
        check("rst_addr",  32'(bus.imem_addr_o),  32'h0010);
        check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        check("rst_inst",  bus.inst_o,            32'd0);
        check("rst_ipc",   32'(bus.inst_pc_o),    32'd0);

        // Zero-wait streaming from RESET_PC.
        do_reset();
        tick();
        check("s1_req",   32'(bus.imem_req_o),   32'd1);
        check("s1_addr",  32'(bus.imem_addr_o),  32'h0010);
        check("s1_valid", 32'(bus.inst_valid_o), 32'd0);
        tick();
        check("s2_addr",  32'(bus.imem_addr_o),  32'h0011);
        check("s2_ipc",   32'(bus.inst_pc_o),    32'h0010);
        check("s2_inst",  bus.inst_o,            32'hA5A5_0010);
        tick();
        check("s3_addr",  32'(bus.imem_addr_o),  32'h0012);
        check("s3_ipc",   32'(bus.inst_pc_o),    32'h0011);

        // Stall from empty: queue fills with two words and fetch stops.
        bus.stall_i = 1'b1;
        do_reset();
        base = ack_cnt;
        tick();
        tick();
        check("st2_req",  32'(bus.imem_req_o),   32'd1);
        tick();
        check("st3_req",  32'(bus.imem_req_o),   32'd0);
        tick();
        tick();
        check("st5_req",  32'(bus.imem_req_o),   32'd0);
        check("st5_push", 32'(ack_cnt - base),   32'd2);
        check("st5_ipc",  32'(bus.inst_pc_o),    32'h0010);
        bus.stall_i = 1'b0;
        tick();
        check("st6_ipc",  32'(bus.inst_pc_o),    32'h0011);
        check("st6_addr", 32'(bus.imem_addr_o),  32'h0012);
        tick();
        check("st7_ipc",  32'(bus.inst_pc_o),    32'h0012);

        // Branch while waiting on a slow memory: outstanding word is dropped.
        ack_delay = 3;
        do_reset();
        tick();
        tick();
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 16'h0040;
        tick();
        bus.branch_i = 1'b0;
        check("bw_req",   32'(bus.imem_req_o),   32'd1);
        check("bw_addr",  32'(bus.imem_addr_o),  32'h0010);
        wait_new_req(16'h0010, 20, "bw_req_to");
        check("bw_naddr", 32'(bus.imem_addr_o),  32'h0040);
        check("bw_nvld",  32'(bus.inst_valid_o), 32'd0);
        wait_valid(20, "bw_vld_to");
        check("bw_ipc",   32'(bus.inst_pc_o),    32'h0040);
        check("bw_inst",  bus.inst_o,            32'hA5A5_0040);

        // Branch coincident with ack: acked word is not pushed.
        ack_delay = 0;
        do_reset();
        tick();
        tick();
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 16'h0080;
        tick();
        bus.branch_i = 1'b0;
        check("ba_valid", 32'(bus.inst_valid_o), 32'd0);
        check("ba_req",   32'(bus.imem_req_o),   32'd0);
        tick();
        check("ba_addr",  32'(bus.imem_addr_o),  32'h0080);
        check("ba_req2",  32'(bus.imem_req_o),   32'd1);
        tick();
        check("ba_ipc",   32'(bus.inst_pc_o),    32'h0080);

        // Two redirects while dropping: latest target wins.
        ack_delay = 3;
        do_reset();
        tick();
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 16'h0100;
        tick();
        bus.branch_addr_i = 16'h0200;
        tick();
        bus.branch_i = 1'b0;
        wait_new_req(16'h0010, 20, "dd_req_to");
        check("dd_addr",  32'(bus.imem_addr_o),  32'h0200);
        wait_valid(20, "dd_vld_to");
        check("dd_ipc",   32'(bus.inst_pc_o),    32'h0200);

        // PC wrap, then asynchronous reset while a request is outstanding.
        ack_delay = 0;
        do_reset();
        tick();
        bus.branch_i      = 1'b1;
        bus.branch_addr_i = 16'hFFFE;
        tick();
        bus.branch_i = 1'b0;
        tick();
        check("wr_a0",    32'(bus.imem_addr_o),  32'hFFFE);
        tick();
        check("wr_a1",    32'(bus.imem_addr_o),  32'hFFFF);
        tick();
        check("wr_a2",    32'(bus.imem_addr_o),  32'h0000);
        check("wr_ipc",   32'(bus.inst_pc_o),    32'hFFFF);
        rst = 1'b1;
        #1;
        check("ar_req",   32'(bus.imem_req_o),   32'd0);
        check("ar_addr",  32'(bus.imem_addr_o),  32'h0010);
        check("ar_valid", 32'(bus.inst_valid_o), 32'd0);
        check("ar_inst",  bus.inst_o,            32'd0);
        check("ar_ipc",   32'(bus.inst_pc_o),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
